// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lstm_pkg
// Description : Shared types and constants for the LSTM cell sequencer:
//               FSM state encoding, operation codes, activation selects and
//               Q-format constants for the default Q5.10 configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MUL_C = 3'd3,
    ST_MUL_H = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Activation requests in issue order: input, forget, cell-candidate,
  // output gate, then tanh of the freshly computed cell state.
  typedef enum logic [2:0] {
    OP_I = 3'd0,
    OP_F = 3'd1,
    OP_G = 3'd2,
    OP_O = 3'd3,
    OP_C = 3'd4
  } op_t;

  localparam logic SEL_TANH    = 1'b0;
  localparam logic SEL_SIGMOID = 1'b1;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_FRAC_SZ = 10;
  localparam int ONE         = 1 << DEF_FRAC_SZ;
  localparam int SAT_MAX     = (1 << (DEF_WIDTH - 1)) - 1;
  localparam int SAT_MIN     = -(1 << (DEF_WIDTH - 1));

  // Gate ops go through sigmoid; the candidate G and the cell state use tanh.
  function automatic logic op_select(op_t op);
    return ((op == OP_G) || (op == OP_C)) ? SEL_TANH : SEL_SIGMOID;
  endfunction

  // Successor in the gate sequence I -> F -> G -> O; C is reached via MUL_C.
  function automatic op_t next_op(op_t op);
    op_t nxt;
    case (op)
      OP_I:    nxt = OP_F;
      OP_F:    nxt = OP_G;
      OP_G:    nxt = OP_O;
      default: nxt = OP_C;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_mac_sat.sv
`default_nettype none
// ============================================================================
// Module      : q_mac_sat
// Description : Combinational signed fixed-point a*b + c*d. Each full-width
//               product is arithmetically shifted back to Q format before the
//               sum, and the sum is saturated to the WIDTH-bit signed range.
// Revision    : 1.0 - initial release
// ============================================================================
module q_mac_sat #(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 10
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH;
  // Largest / smallest WIDTH-bit signed values, sign-extended to the sum width.
  localparam logic signed [PW:0] SUM_MAX = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW:0] SUM_MIN = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [PW-1:0] prod_ab;
  logic signed [PW-1:0] prod_cd;
  logic signed [PW-1:0] shr_ab;
  logic signed [PW-1:0] shr_cd;
  logic signed [PW:0]   sum;

  // Full-precision products, floor-rescaled, summed one bit wider, then clamped.
  always_comb begin
    prod_ab = PW'(a) * PW'(b);
    prod_cd = PW'(c) * PW'(d);
    shr_ab  = prod_ab >>> FRAC_SZ;
    shr_cd  = prod_cd >>> FRAC_SZ;
    sum     = (PW + 1)'(shr_ab) + (PW + 1)'(shr_cd);
    if (sum > SUM_MAX) begin
      y = SUM_MAX[WIDTH-1:0];
    end else if (sum < SUM_MIN) begin
      y = SUM_MIN[WIDTH-1:0];
    end else begin
      y = sum[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lstm_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lstm_cell_sequencer
// Description : Initiator-side controller for one LSTM cell element. Issues
//               the five activations (I, F, G, O sigmoid/tanh, then tanh of
//               the new cell state) one at a time over a start/done handshake
//               and combines the results into c_out and h_out.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_cell_sequencer
  import lstm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] pre_i,
  input  logic signed [WIDTH-1:0] pre_f,
  input  logic signed [WIDTH-1:0] pre_g,
  input  logic signed [WIDTH-1:0] pre_o,
  input  logic signed [WIDTH-1:0] c_prev,
  output logic                    busy,
  output logic signed [WIDTH-1:0] c_out,
  output logic signed [WIDTH-1:0] h_out,
  output logic                    done,
  output logic                    act_start,
  output logic signed [WIDTH-1:0] act_z,
  output logic                    act_select,
  input  logic signed [WIDTH-1:0] act_result,
  input  logic                    act_done
);

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic signed [WIDTH-1:0] pre_i_q, pre_i_d;
  logic signed [WIDTH-1:0] pre_f_q, pre_f_d;
  logic signed [WIDTH-1:0] pre_g_q, pre_g_d;
  logic signed [WIDTH-1:0] pre_o_q, pre_o_d;
  logic signed [WIDTH-1:0] c_prev_q, c_prev_d;
  logic signed [WIDTH-1:0] a_i_q, a_i_d;
  logic signed [WIDTH-1:0] a_f_q, a_f_d;
  logic signed [WIDTH-1:0] a_g_q, a_g_d;
  logic signed [WIDTH-1:0] a_o_q, a_o_d;
  logic signed [WIDTH-1:0] t_c_q, t_c_d;
  logic signed [WIDTH-1:0] c_out_q, c_out_d;
  logic signed [WIDTH-1:0] h_out_q, h_out_d;
  logic signed [WIDTH-1:0] act_z_q, act_z_d;
  logic                    act_sel_q, act_sel_d;

  logic signed [WIDTH-1:0] mac_a, mac_b, mac_c, mac_d, mac_y;

  // MUL_H reuses the MAC for a_o*t_c alone; every other state presents the
  // cell-state terms so MUL_C sees f*c_prev + i*g.
  always_comb begin
    if (state_q == ST_MUL_H) begin
      mac_a = a_o_q;
      mac_b = t_c_q;
      mac_c = '0;
      mac_d = '0;
    end else begin
      mac_a = a_f_q;
      mac_b = c_prev_q;
      mac_c = a_i_q;
      mac_d = a_g_q;
    end
  end

  q_mac_sat #(
    .WIDTH   (WIDTH),
    .FRAC_SZ (FRAC_SZ)
  ) u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .d (mac_d),
    .y (mac_y)
  );

  // Next-state logic; the operand/select for an ISSUE is loaded on entry so
  // it stays frozen through the following WAIT.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pre_i_d   = pre_i_q;
    pre_f_d   = pre_f_q;
    pre_g_d   = pre_g_q;
    pre_o_d   = pre_o_q;
    c_prev_d  = c_prev_q;
    a_i_d     = a_i_q;
    a_f_d     = a_f_q;
    a_g_d     = a_g_q;
    a_o_d     = a_o_q;
    t_c_d     = t_c_q;
    c_out_d   = c_out_q;
    h_out_d   = h_out_q;
    act_z_d   = act_z_q;
    act_sel_d = act_sel_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pre_i_d   = pre_i;
          pre_f_d   = pre_f;
          pre_g_d   = pre_g;
          pre_o_d   = pre_o;
          c_prev_d  = c_prev;
          op_d      = OP_I;
          act_z_d   = pre_i;
          act_sel_d = op_select(OP_I);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (act_done) begin
          case (op_q)
            OP_I:    a_i_d = act_result;
            OP_F:    a_f_d = act_result;
            OP_G:    a_g_d = act_result;
            OP_O:    a_o_d = act_result;
            default: t_c_d = act_result;
          endcase
          if (op_q == OP_O) begin
            state_d = ST_MUL_C;
          end else if (op_q == OP_C) begin
            state_d = ST_MUL_H;
          end else begin
            op_d      = next_op(op_q);
            act_sel_d = op_select(next_op(op_q));
            case (op_q)
              OP_I:    act_z_d = pre_f_q;
              OP_F:    act_z_d = pre_g_q;
              default: act_z_d = pre_o_q;
            endcase
            state_d = ST_ISSUE;
          end
        end
      end
      ST_MUL_C: begin
        c_out_d   = mac_y;
        op_d      = OP_C;
        act_z_d   = mac_y;
        act_sel_d = op_select(OP_C);
        state_d   = ST_ISSUE;
      end
      ST_MUL_H: begin
        h_out_d = mac_y;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_I;
      pre_i_q   <= '0;
      pre_f_q   <= '0;
      pre_g_q   <= '0;
      pre_o_q   <= '0;
      c_prev_q  <= '0;
      a_i_q     <= '0;
      a_f_q     <= '0;
      a_g_q     <= '0;
      a_o_q     <= '0;
      t_c_q     <= '0;
      c_out_q   <= '0;
      h_out_q   <= '0;
      act_z_q   <= '0;
      act_sel_q <= SEL_TANH;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pre_i_q   <= pre_i_d;
      pre_f_q   <= pre_f_d;
      pre_g_q   <= pre_g_d;
      pre_o_q   <= pre_o_d;
      c_prev_q  <= c_prev_d;
      a_i_q     <= a_i_d;
      a_f_q     <= a_f_d;
      a_g_q     <= a_g_d;
      a_o_q     <= a_o_d;
      t_c_q     <= t_c_d;
      c_out_q   <= c_out_d;
      h_out_q   <= h_out_d;
      act_z_q   <= act_z_d;
      act_sel_q <= act_sel_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign act_start  = (state_q == ST_ISSUE);
  assign act_z      = act_z_q;
  assign act_select = act_sel_q;
  assign c_out      = c_out_q;
  assign h_out      = h_out_q;

endmodule
`default_nettype wire

// File: tb/tb_lstm_cell_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lstm_cell_sequencer
// Description : Self-checking bench for lstm_cell_sequencer with a behavioural
//               activation unit of configurable latency and a reference model
//               of the LSTM cell arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_cell_sequencer;
  import lstm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] pre_i = '0, pre_f = '0, pre_g = '0, pre_o = '0, c_prev = '0;
  logic busy, done, act_start, act_select;
  logic signed [15:0] c_out, h_out, act_z, act_result;
  logic act_done;

  logic               m_done = 1'b0;
  logic signed [15:0] m_result = '0;
  logic               spur_done = 1'b0;
  logic signed [15:0] spur_result = 16'sh7fff;

  assign act_done   = m_done | spur_done;
  assign act_result = spur_done ? spur_result : m_result;

  int vectors = 0;
  int miscompares = 0;

  lstm_cell_sequencer #(.WIDTH(16), .FRAC_SZ(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pre_i      (pre_i),
    .pre_f      (pre_f),
    .pre_g      (pre_g),
    .pre_o      (pre_o),
    .c_prev     (c_prev),
    .busy       (busy),
    .c_out      (c_out),
    .h_out      (h_out),
    .done       (done),
    .act_start  (act_start),
    .act_z      (act_z),
    .act_select (act_select),
    .act_result (act_result),
    .act_done   (act_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural activation unit ----------------
  int   L = 3;
  logic force_en [5] = '{default: 1'b0};
  int   force_val [5] = '{default: 0};

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Simple monotone stand-ins for sigmoid/tanh; per-request overrides win.
  function automatic int act_model(int k, logic [15:0] z, logic sel);
    int zi;
    zi = int'($signed(z));
    if (k >= 0 && k < 5 && force_en[k]) return force_val[k];
    if (sel) return clampi(ONE / 2 + (zi >>> 3), 0, ONE);
    return clampi(zi, -ONE, ONE);
  endfunction

  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_z = '0;
  logic        m_sel = 1'b0;
  int          issue_cnt = 0, done_cnt = 0, hold_err = 0;
  logic        seq_sel [8];
  logic [15:0] seq_z [8];

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (reset) begin
      m_pend    <= 1'b0;
      m_cnt     <= 0;
      m_result  <= '0;
      issue_cnt <= 0;
      done_cnt  <= 0;
      hold_err  <= 0;
    end else begin
      if (start && !busy) begin
        issue_cnt <= 0;
        done_cnt  <= 0;
        hold_err  <= 0;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (m_pend) begin
        if (act_z !== m_z || act_select !== m_sel) hold_err <= hold_err + 1;
        if (m_cnt == 1) begin
          m_done   <= 1'b1;
          m_result <= 16'(act_model(issue_cnt - 1, m_z, m_sel));
          m_pend   <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (act_start) begin
        m_pend <= 1'b1;
        m_cnt  <= L - 1;
        m_z    <= act_z;
        m_sel  <= act_select;
        if (issue_cnt < 8) begin
          seq_sel[issue_cnt] <= act_select;
          seq_z[issue_cnt]   <= act_z;
        end
        issue_cnt <= issue_cnt + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int   exp_z [5];
  logic exp_sel [5];
  int   exp_c, exp_h;

  function automatic int sat16(longint v);
    return (v > SAT_MAX) ? SAT_MAX : ((v < SAT_MIN) ? SAT_MIN : int'(v));
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic compute_expected(input int pi, input int pf, input int pg, input int po, input int cp);
    int ai, af, ag, ao, tc;
    ai    = act_model(0, 16'(pi), 1'b1);
    af    = act_model(1, 16'(pf), 1'b1);
    ag    = act_model(2, 16'(pg), 1'b0);
    ao    = act_model(3, 16'(po), 1'b1);
    exp_c = sat16(((longint'(af) * cp) >>> 10) + ((longint'(ai) * ag) >>> 10));
    tc    = act_model(4, 16'(exp_c), 1'b0);
    exp_h = sat16((longint'(ao) * tc) >>> 10);
    exp_z   = '{pi, pf, pg, po, exp_c};
    exp_sel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  endtask

  // One full transaction; optional re-pulse of start and spurious act_done
  // at given cycles (cycle 0 = the cycle in which start is accepted).
  task automatic run_op(input string name, input int lat,
                        input int pi, input int pf, input int pg, input int po, input int cp,
                        input int repulse_at, input int spur_at);
    int n, done_at, busy_low;
    L = lat;
    pre_i = 16'(pi); pre_f = 16'(pf); pre_g = 16'(pg); pre_o = 16'(po); c_prev = 16'(cp);
    compute_expected(pi, pf, pg, po, cp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; done_at = -1; busy_low = 0;
    while (n < 400 && done_at < 0) begin
      if (done) begin
        done_at = n;
      end else begin
        if (!busy) busy_low++;
        start = (n == repulse_at);
        if (n == repulse_at) begin
          pre_i = 16'(rnd16()); pre_f = 16'(rnd16()); pre_g = 16'(rnd16());
          pre_o = 16'(rnd16()); c_prev = 16'(rnd16());
        end
        spur_done = (n == spur_at);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    spur_done = 1'b0;

    vectors++;
    if (done_at != 5 * lat + 8) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, 5 * lat + 8);
    end
    vectors++;
    if (c_out !== 16'(exp_c)) begin
      miscompares++;
      $display("FAIL %s c_out: got %0d expected %0d", name, $signed(c_out), exp_c);
    end
    vectors++;
    if (h_out !== 16'(exp_h)) begin
      miscompares++;
      $display("FAIL %s h_out: got %0d expected %0d", name, $signed(h_out), exp_h);
    end
    vectors++;
    if (busy_low != 0 || issue_cnt != 5 || hold_err != 0) begin
      miscompares++;
      $display("FAIL %s handshake: busy_low=%0d issues=%0d hold_err=%0d expected 0/5/0",
               name, busy_low, issue_cnt, hold_err);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (seq_sel[k] !== exp_sel[k] || seq_z[k] !== 16'(exp_z[k])) begin
        miscompares++;
        $display("FAIL %s request%0d: got sel=%0b z=%0d expected sel=%0b z=%0d",
                 name, k, seq_sel[k], $signed(seq_z[k]), exp_sel[k], exp_z[k]);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1 || c_out !== 16'(exp_c)) begin
      miscompares++;
      $display("FAIL %s after_done: done=%0b busy=%0b done_pulses=%0d c_out=%0d expected 0/0/1/%0d",
               name, done, busy, done_cnt, $signed(c_out), exp_c);
    end
  endtask

  task automatic clear_forces();
    for (int k = 0; k < 5; k++) force_en[k] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || act_start !== 1'b0 || act_select !== 1'b0 ||
        act_z !== 16'd0 || c_out !== 16'd0 || h_out !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%0b done=%0b act_start=%0b sel=%0b z=%h c=%h h=%h expected all 0",
               busy, done, act_start, act_select, act_z, c_out, h_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    run_op("zero", 3, 0, 0, 0, 0, 0, -1, -1);
    vectors++;
    if (c_out !== 16'd0 || h_out !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_literal: got c=%0d h=%0d expected 0 0", $signed(c_out), $signed(h_out));
    end
  endtask

  task automatic test_known();
    force_en[4] = 1'b1; force_val[4] = 987;
    run_op("known", 3, -8192, 8192, 0, 8192, 2048, -1, -1);
    vectors++;
    if (c_out !== 16'sd2048 || h_out !== 16'sd987) begin
      miscompares++;
      $display("FAIL known_literal: got c=%0d h=%0d expected 2048 987", $signed(c_out), $signed(h_out));
    end
    clear_forces();
  endtask

  task automatic test_reset_mid();
    int n;
    L = 3;
    pre_i = 16'sd100; pre_f = 16'sd200; pre_g = 16'sd300; pre_o = 16'sd400; c_prev = 16'sd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 2 * L + 4) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || act_start !== 1'b0 || act_select !== 1'b0 ||
        act_z !== 16'd0 || c_out !== 16'd0 || h_out !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%0b done=%0b act_start=%0b sel=%0b z=%h c=%h h=%h expected all 0",
               busy, done, act_start, act_select, act_z, c_out, h_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("after_reset", 3, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), -1, -1);
  endtask

  task automatic test_saturation();
    force_en[0] = 1'b1; force_val[0] = 1024;
    force_en[1] = 1'b1; force_val[1] = 1024;
    force_en[2] = 1'b1; force_val[2] = 1024;
    run_op("sat_pos", 2, rnd16(), rnd16(), rnd16(), rnd16(), 32767, -1, -1);
    vectors++;
    if (c_out !== 16'sh7fff) begin
      miscompares++;
      $display("FAIL sat_pos_literal: got c=%0d expected 32767", $signed(c_out));
    end
    force_val[2] = -1024;
    run_op("sat_neg", 2, rnd16(), rnd16(), rnd16(), rnd16(), -32768, -1, -1);
    vectors++;
    if (c_out !== 16'sh8000) begin
      miscompares++;
      $display("FAIL sat_neg_literal: got c=%0d expected -32768", $signed(c_out));
    end
    clear_forces();
  endtask

  task automatic test_floor();
    force_en[0] = 1'b1; force_val[0] = 0;
    force_en[1] = 1'b1; force_val[1] = 512;
    run_op("floor", 4, rnd16(), rnd16(), rnd16(), rnd16(), -3, -1, -1);
    vectors++;
    if (c_out !== 16'shfffe) begin
      miscompares++;
      $display("FAIL floor_literal: got c=%0d expected -2", $signed(c_out));
    end
    clear_forces();
  endtask

  task automatic test_busy_start();
    run_op("busy_start", 4, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 3, 4 * 4 + 5);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_op("random", int'($urandom_range(5, 2)), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      run_op("back_to_back", 2 + r, rnd16() >>> 2, rnd16() >>> 2, rnd16() >>> 2,
             rnd16() >>> 2, rnd16(), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_reset_mid();
    test_saturation();
    test_floor();
    test_busy_start();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
